// File: rtl/icb_ppi_splitter.sv
// ICB 1-to-N splitter: address decode to N_SLV slaves plus an internal error target,
// with an ordering FIFO that returns responses strictly in command order.
module icb_ppi_splitter #(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int N_SLV = 4,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {AW'(32'h1004_0000), AW'(32'h1003_0000),
                                               AW'(32'h1001_3000), AW'(32'h1001_2000)},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {AW'(32'hFFFF_0000), AW'(32'hFFFF_0000),
                                               AW'(32'hFFFF_F000), AW'(32'hFFFF_F000)},
    parameter int OUTS_NUM = 2,
    parameter int CMD_PIPE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SLV-1:0]    slv_enable,
    input  logic                i_icb_cmd_valid,
    output logic                i_icb_cmd_ready,
    input  logic [AW-1:0]       i_icb_cmd_addr,
    input  logic                i_icb_cmd_read,
    input  logic [DW-1:0]       i_icb_cmd_wdata,
    input  logic [DW/8-1:0]     i_icb_cmd_wmask,
    output logic                i_icb_rsp_valid,
    input  logic                i_icb_rsp_ready,
    output logic                i_icb_rsp_err,
    output logic [DW-1:0]       i_icb_rsp_rdata,
    output logic [N_SLV-1:0]    o_icb_cmd_valid,
    input  logic [N_SLV-1:0]    o_icb_cmd_ready,
    output logic [AW-1:0]       o_icb_cmd_addr,
    output logic                o_icb_cmd_read,
    output logic [DW-1:0]       o_icb_cmd_wdata,
    output logic [DW/8-1:0]     o_icb_cmd_wmask,
    input  logic [N_SLV-1:0]    o_icb_rsp_valid,
    output logic [N_SLV-1:0]    o_icb_rsp_ready,
    input  logic [N_SLV-1:0]    o_icb_rsp_err,
    input  logic [N_SLV*DW-1:0] o_icb_rsp_rdata,
    output logic [15:0]         dec_err_cnt
);
    localparam int TW  = $clog2(N_SLV + 1);
    localparam int CW  = $clog2(OUTS_NUM + 1);
    localparam int PW  = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam int MW  = DW / 8;
    localparam int PKW = AW + 1 + DW + MW;
    localparam logic [TW-1:0] ERR_ID   = TW'(N_SLV);
    localparam logic [CW-1:0] OUTS_MAX = CW'(OUTS_NUM);

    logic           c_valid, c_ready;
    logic [PKW-1:0] in_pkt, c_pkt;
    logic [AW-1:0]  c_addr;
    logic           c_read;
    logic [DW-1:0]  c_wdata;
    logic [MW-1:0]  c_wmask;

    assign in_pkt = {i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_cmd_wmask};
    assign {c_addr, c_read, c_wdata, c_wmask} = c_pkt;

    generate
        if (CMD_PIPE != 0) begin : g_skid
            // Two entries let upstream ready depend only on occupancy, never on downstream.
            logic [PKW-1:0] buf_q [2];
            logic           sk_wp_q, sk_rp_q;
            logic [1:0]     sk_n_q, sk_n_d;
            logic           sk_push, sk_pop;

            assign sk_push = i_icb_cmd_valid & i_icb_cmd_ready;
            assign sk_pop  = c_valid & c_ready;
            assign sk_n_d  = sk_n_q + {1'b0, sk_push} - {1'b0, sk_pop};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    buf_q[0] <= '0;
                    buf_q[1] <= '0;
                    sk_wp_q  <= 1'b0;
                    sk_rp_q  <= 1'b0;
                    sk_n_q   <= 2'd0;
                end else begin
                    if (sk_push) begin
                        buf_q[sk_wp_q] <= in_pkt;
                        sk_wp_q        <= ~sk_wp_q;
                    end
                    if (sk_pop) sk_rp_q <= ~sk_rp_q;
                    sk_n_q <= sk_n_d;
                end
            end

            assign i_icb_cmd_ready = (sk_n_q != 2'd2);
            assign c_valid         = (sk_n_q != 2'd0);
            assign c_pkt           = buf_q[sk_rp_q];
        end else begin : g_bypass
            assign c_valid         = i_icb_cmd_valid;
            assign c_pkt           = in_pkt;
            assign i_icb_cmd_ready = c_ready;
        end
    endgenerate

    logic [TW-1:0] ord_q [OUTS_NUM];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   dec_err_q, dec_err_d;
    logic [TW-1:0] tgt, head;
    logic          hit, tgt_rdy, has_room, head_vld, push, pop;

    always_comb begin
        tgt = ERR_ID;
        hit = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!hit && slv_enable[i] &&
                ((c_addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
                tgt = TW'(i);
                hit = 1'b1;
            end
        end
    end

    assign has_room = (cnt_q < OUTS_MAX);

    always_comb begin
        tgt_rdy         = 1'b1;
        o_icb_cmd_valid = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (tgt == TW'(i)) begin
                tgt_rdy            = o_icb_cmd_ready[i];
                o_icb_cmd_valid[i] = c_valid & has_room;
            end
        end
    end

    assign c_ready         = has_room & tgt_rdy;
    assign o_icb_cmd_addr  = c_addr;
    assign o_icb_cmd_read  = c_read;
    assign o_icb_cmd_wdata = c_wdata;
    assign o_icb_cmd_wmask = c_wmask;

    assign head_vld = (cnt_q != '0);
    assign head     = ord_q[rp_q];

    // The error target answers from the FIFO head, so it is naturally one cycle behind acceptance.
    always_comb begin
        i_icb_rsp_valid = 1'b0;
        i_icb_rsp_err   = 1'b0;
        i_icb_rsp_rdata = '0;
        o_icb_rsp_ready = '0;
        if (head_vld) begin
            if (head == ERR_ID) begin
                i_icb_rsp_valid = 1'b1;
                i_icb_rsp_err   = 1'b1;
            end else begin
                for (int i = 0; i < N_SLV; i++) begin
                    if (head == TW'(i)) begin
                        i_icb_rsp_valid    = o_icb_rsp_valid[i];
                        i_icb_rsp_err      = o_icb_rsp_err[i];
                        i_icb_rsp_rdata    = o_icb_rsp_rdata[i*DW +: DW];
                        o_icb_rsp_ready[i] = i_icb_rsp_ready;
                    end
                end
            end
        end
    end

    assign push      = c_valid & c_ready;
    assign pop       = i_icb_rsp_valid & i_icb_rsp_ready;
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
    assign dec_err_d = (push && tgt == ERR_ID && dec_err_q != 16'hFFFF) ? dec_err_q + 16'd1 : dec_err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS_NUM - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUTS_NUM; i++) ord_q[i] <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            dec_err_q <= '0;
        end else begin
            if (push) begin
                ord_q[wp_q] <= tgt;
                wp_q        <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
            cnt_q     <= cnt_d;
            dec_err_q <= dec_err_d;
        end
    end

    assign dec_err_cnt = dec_err_q;

endmodule

// File: tb/tb_icb_ppi_splitter.sv
// Directed bench: one splitter without command pipe, one with the skid buffer
// driven against queue-based slave responders.
module tb_icb_ppi_splitter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] en;
    always #5 clk = ~clk;

    // unpiped instance
    logic         cv, crdy, cread, rv, rrdy, rerr, oread;
    logic [63:0]  caddr, cwdata, rdata, oaddr, owdata;
    logic [7:0]   cwmask, owmask;
    logic [3:0]   ocv, ocrdy, orv, orrdy, orerr;
    logic [255:0] ordata;
    logic [15:0]  decnt;

    icb_ppi_splitter dut (
        .clk(clk), .rst(rst), .slv_enable(en),
        .i_icb_cmd_valid(cv), .i_icb_cmd_ready(crdy), .i_icb_cmd_addr(caddr),
        .i_icb_cmd_read(cread), .i_icb_cmd_wdata(cwdata), .i_icb_cmd_wmask(cwmask),
        .i_icb_rsp_valid(rv), .i_icb_rsp_ready(rrdy), .i_icb_rsp_err(rerr), .i_icb_rsp_rdata(rdata),
        .o_icb_cmd_valid(ocv), .o_icb_cmd_ready(ocrdy), .o_icb_cmd_addr(oaddr),
        .o_icb_cmd_read(oread), .o_icb_cmd_wdata(owdata), .o_icb_cmd_wmask(owmask),
        .o_icb_rsp_valid(orv), .o_icb_rsp_ready(orrdy), .o_icb_rsp_err(orerr),
        .o_icb_rsp_rdata(ordata), .dec_err_cnt(decnt)
    );

    // piped instance
    logic         pcv, pcrdy, prv, prrdy, prerr, poread;
    logic [63:0]  paddr, prdata, poaddr, powdata;
    logic [7:0]   powmask;
    logic [3:0]   pocv, pocrdy, porv, porrdy;
    logic [255:0] pordata;
    logic [15:0]  pdecnt;

    icb_ppi_splitter #(.CMD_PIPE(1)) dut_p (
        .clk(clk), .rst(rst), .slv_enable(en),
        .i_icb_cmd_valid(pcv), .i_icb_cmd_ready(pcrdy), .i_icb_cmd_addr(paddr),
        .i_icb_cmd_read(1'b1), .i_icb_cmd_wdata(64'h0), .i_icb_cmd_wmask(8'h0),
        .i_icb_rsp_valid(prv), .i_icb_rsp_ready(prrdy), .i_icb_rsp_err(prerr), .i_icb_rsp_rdata(prdata),
        .o_icb_cmd_valid(pocv), .o_icb_cmd_ready(pocrdy), .o_icb_cmd_addr(poaddr),
        .o_icb_cmd_read(poread), .o_icb_cmd_wdata(powdata), .o_icb_cmd_wmask(powmask),
        .o_icb_rsp_valid(porv), .o_icb_rsp_ready(porrdy), .o_icb_rsp_err(4'h0),
        .o_icb_rsp_rdata(pordata), .dec_err_cnt(pdecnt)
    );

    // Slaves of the piped instance answer with the command address as read data, stalling randomly.
    logic [63:0] sq [4][$];
    logic [3:0]  s_chs, s_rhs;
    logic [63:0] s_cap;
    always begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pocrdy[i] = ($urandom_range(0, 2) != 0);
            porv[i]   = (sq[i].size() != 0) && ($urandom_range(0, 2) != 0);
            pordata[i*64 +: 64] = (sq[i].size() != 0) ? sq[i][0] : 64'h0;
        end
        #1;
        s_chs = pocv & pocrdy;
        s_rhs = porv & porrdy;
        s_cap = poaddr;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (s_rhs[i]) void'(sq[i].pop_front());
            if (s_chs[i]) sq[i].push_back(s_cap);
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] pa [8];
    logic        pe [8];
    int sent, got, pc;
    logic hs_c;

    initial begin
        rst = 1'b0; en = 4'hF;
        cv = 0; caddr = '0; cread = 0; cwdata = '0; cwmask = '0; rrdy = 0;
        ocrdy = '0; orv = '0; orerr = '0; ordata = '0;
        pcv = 0; paddr = '0; prrdy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ocv", ocv, 0);
        chk("rst_rv", rv, 0);
        chk("rst_orrdy", orrdy, 0);
        chk("rst_decnt", decnt, 0);
        chk("rst_p_rv", prv, 0);
        rst = 1'b1;

        // write to slave0, response forwarded
        caddr = 64'h1001_2008; cread = 0; cwdata = 64'hDEAD_BEEF; cwmask = 8'hFF;
        cv = 1; ocrdy = 4'b0001; rrdy = 1;
        #1;
        chk("wr_ocv", ocv, 4'b0001);
        chk("wr_crdy", crdy, 1);
        chk("wr_wdata", owdata, 64'hDEAD_BEEF);
        tick;
        cv = 0;
        #1;
        chk("wr_rv_wait", rv, 0);
        chk("wr_orrdy", orrdy, 4'b0001);
        orv = 4'b0001; ordata[63:0] = 64'hAB;
        #1;
        chk("wr_rv", rv, 1);
        chk("wr_rdata", rdata, 64'hAB);
        chk("wr_err", rerr, 0);
        tick;
        orv = 0;
        #1;
        chk("wr_empty_rv", rv, 0);
        chk("wr_empty_orrdy", orrdy, 0);

        // decode error
        caddr = 64'h2000_0000; cread = 1; cv = 1; ocrdy = 0; rrdy = 0;
        #1;
        chk("de_crdy", crdy, 1);
        chk("de_ocv", ocv, 0);
        tick;
        cv = 0;
        #1;
        chk("de_rv", rv, 1);
        chk("de_err", rerr, 1);
        chk("de_rdata", rdata, 0);
        chk("de_cnt", decnt, 1);
        tick;
        chk("de_hold", rv, 1);
        rrdy = 1;
        tick;
        chk("de_pop", rv, 0);

        // ordering with two outstanding
        caddr = 64'h1001_3010; cv = 1; ocrdy = 4'b0010;
        #1;
        chk("ord_ocv1", ocv, 4'b0010);
        tick;
        caddr = 64'h1003_0020; ocrdy = 4'b0100;
        #1;
        chk("ord_ocv2", ocv, 4'b0100);
        chk("ord_crdy2", crdy, 1);
        tick;
        caddr = 64'h1004_0030; ocrdy = 4'b1000;
        orv = 4'b0110; ordata[127:64] = 64'h11; ordata[191:128] = 64'h22;
        #1;
        chk("ord_full_crdy", crdy, 0);
        chk("ord_full_ocv", ocv, 0);
        chk("ord_first", rdata, 64'h11);
        chk("ord_hold2", orrdy, 4'b0010);
        tick;
        orv = 4'b0100;
        #1;
        chk("ord_crdy3", crdy, 1);
        chk("ord_ocv3", ocv, 4'b1000);
        chk("ord_second", rdata, 64'h22);
        chk("ord_orrdy2", orrdy, 4'b0100);
        tick;
        cv = 0; orv = 0;
        #1;
        chk("ord_head3_rv", rv, 0);
        chk("ord_head3_rdy", orrdy, 4'b1000);
        orv = 4'b1000; ordata[255:192] = 64'h33;
        #1;
        chk("ord_third", rdata, 64'h33);
        tick;
        orv = 0;
        #1;
        chk("ord_empty", orrdy, 0);

        // disabled slave decodes to error, re-enabled routes normally
        en = 4'b1110; caddr = 64'h1001_2000; cv = 1; ocrdy = 4'b0001;
        #1;
        chk("dis_ocv", ocv, 0);
        chk("dis_crdy", crdy, 1);
        tick;
        cv = 0;
        #1;
        chk("dis_err", rerr, 1);
        chk("dis_cnt", decnt, 2);
        tick;
        en = 4'hF; cv = 1;
        #1;
        chk("ena_ocv", ocv, 4'b0001);
        tick;
        cv = 0; orv = 4'b0001; ordata[63:0] = 64'h5A;
        #1;
        chk("ena_rdata", rdata, 64'h5A);
        chk("ena_err", rerr, 0);
        tick;
        orv = 0;

        // reset with two outstanding
        caddr = 64'h1001_2000; cv = 1; ocrdy = 4'b0001; rrdy = 0;
        tick;
        caddr = 64'h2000_0000;
        tick;
        cv = 0;
        #1;
        chk("rr_cnt_pre", decnt, 3);
        chk("rr_rv_pre", rv, 0);
        rst = 1'b0; orv = 4'b0001; ordata[63:0] = 64'hEE; rrdy = 1;
        #1;
        chk("rr_rv_in", rv, 0);
        chk("rr_orrdy_in", orrdy, 0);
        chk("rr_cnt_in", decnt, 0);
        tick;
        rst = 1'b1;
        #1;
        chk("rr_orrdy_post", orrdy, 0);
        chk("rr_rv_post", rv, 0);
        tick;
        chk("rr_rv_late", rv, 0);
        orv = 0; caddr = 64'h1001_3000; cv = 1; ocrdy = 4'b0010;
        #1;
        chk("rr_new_ocv", ocv, 4'b0010);
        tick;
        cv = 0; orv = 4'b0010; ordata[127:64] = 64'h77;
        #1;
        chk("rr_new_rv", rv, 1);
        chk("rr_new_rdata", rdata, 64'h77);
        tick;
        orv = 0;
        #1;
        chk("rr_new_done", rv, 0);

        // piped instance: 8 back-to-back commands under random stalls
        pa[0] = 64'h1001_2010; pe[0] = 0;
        pa[1] = 64'h1001_3020; pe[1] = 0;
        pa[2] = 64'h1003_0030; pe[2] = 0;
        pa[3] = 64'h1004_0040; pe[3] = 0;
        pa[4] = 64'h2000_0050; pe[4] = 1;
        pa[5] = 64'h1003_0060; pe[5] = 0;
        pa[6] = 64'h1001_2070; pe[6] = 0;
        pa[7] = 64'h1001_3080; pe[7] = 0;
        sent = 0; got = 0; pc = 0;
        while (got < 8 && pc < 600) begin
            @(negedge clk);
            pcv   = (sent < 8);
            paddr = pa[(sent < 8) ? sent : 7];
            prrdy = ($urandom_range(0, 2) != 0);
            #1;
            if (pc == 0) begin
                chk("p_lat0_ocv", pocv, 0);
                chk("p_lat0_rdy", pcrdy, 1);
            end
            if (pc == 1) chk("p_lat1_ocv", pocv, 4'b0001);
            hs_c = pcv & pcrdy;
            if (prv && prrdy) begin
                chk("p_err", prerr, pe[got]);
                chk("p_rdata", prdata, pe[got] ? 64'h0 : pa[got]);
                got++;
            end
            @(posedge clk);
            if (hs_c) sent++;
            pc++;
        end
        chk("p_rsp_count", got, 8);
        chk("p_cmd_count", sent, 8);
        @(negedge clk);
        pcv = 0; prrdy = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("p_no_dup", prv, 0);
        end
        chk("p_decnt", pdecnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
